// File: rtl/fifo_if.sv
// Producer/consumer bundle for the synchronous FIFO.
// FIFO_ERR_FLAGS_EN adds the sticky overflow/underflow status signals.
interface fifo_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] input_data;
  logic                  write_enable;
  logic                  read_enable;
  logic [DATA_WIDTH-1:0] output_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [AW:0]           fifo_count;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  // Master is the side issuing requests; slave is the FIFO itself.
  modport master (
    output input_data,
    output write_enable,
    output read_enable,
    input  output_data,
    input  fifo_full,
    input  fifo_empty,
`ifdef FIFO_ERR_FLAGS_EN
    input  overflow,
    input  underflow,
`endif
    input  fifo_count
  );

  modport slave (
    input  input_data,
    input  write_enable,
    input  read_enable,
    output output_data,
    output fifo_full,
    output fifo_empty,
`ifdef FIFO_ERR_FLAGS_EN
    output overflow,
    output underflow,
`endif
    output fifo_count
  );

endinterface

// File: rtl/fifo.sv
// Single-clock FIFO with registered read data and registered status flags.
// Define FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  fifo_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW:0]           wp_q, wp_d;
  logic [AW:0]           rp_q, rp_d;
  logic [AW:0]           count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic wr_ok;
  logic rd_ok;

  // Acceptance uses the registered flags, so a full FIFO rejects a write
  // even when a read drains an entry on the same edge.
  always_comb begin
    wr_ok = bus.write_enable & ~full_q;
    rd_ok = bus.read_enable & ~empty_q;
  end

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    rdata_d = rdata_q;

    if (wr_ok) begin
      wp_d = wp_q + (AW + 1)'(1);
    end
    if (rd_ok) begin
      rp_d    = rp_q + (AW + 1)'(1);
      rdata_d = mem[rp_q[AW-1:0]];
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase

    empty_d = (wp_d == rp_d);
    full_d  = (wp_d[AW-1:0] == rp_d[AW-1:0]) && (wp_d[AW] != rp_d[AW]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wp_q[AW-1:0]] <= bus.input_data;
    end
  end

  assign bus.output_data = rdata_q;
  assign bus.fifo_full   = full_q;
  assign bus.fifo_empty  = empty_q;
  assign bus.fifo_count  = count_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q | (bus.write_enable & full_q);
    underflow_d = underflow_q | (bus.read_enable & empty_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo against a queue-based reference model.
module tb_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_out;
  logic          m_ovf;
  logic          m_unf;
  int            n_checks;
  int            n_pass;

  task automatic model_reset();
    mq.delete();
    m_out = '0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock of stimulus; the model advances from its pre-edge state.
  task automatic step(input logic we, input logic re, input logic [DW-1:0] d);
    bit wr_ok;
    bit rd_ok;
    bus.write_enable = we;
    bus.read_enable  = re;
    bus.input_data   = d;
    @(posedge clk);
    wr_ok = we && (mq.size() < DEPTH);
    rd_ok = re && (mq.size() > 0);
    if (we && mq.size() == DEPTH) m_ovf = 1'b1;
    if (re && mq.size() == 0) m_unf = 1'b1;
    if (rd_ok) m_out = mq.pop_front();
    if (wr_ok) mq.push_back(d);
    #1;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
  endtask

  task automatic test_reset();
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    bus.input_data   = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.fifo_empty);
    else n_pass++;
    n_checks++;
    if (bus.fifo_full !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.fifo_full);
    else n_pass++;
    n_checks++;
    if (bus.fifo_count !== '0) $display("FAIL reset_count: got %0d want 0", bus.fifo_count);
    else n_pass++;
    n_checks++;
    if (bus.output_data !== '0) $display("FAIL reset_data: got %h want 0", bus.output_data);
    else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
    n_checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
      $display("FAIL reset_errflags: got %b%b want 00", bus.overflow, bus.underflow);
    else n_pass++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 16'(256 + i));
      n_checks++;
      if (bus.fifo_count !== 5'(i + 1) || bus.fifo_full !== (i == 15) || bus.fifo_empty !== 1'b0)
        $display("FAIL fill_step %0d: got count=%0d full=%b empty=%b want count=%0d full=%b empty=0",
                 i, bus.fifo_count, bus.fifo_full, bus.fifo_empty, i + 1, (i == 15));
      else n_pass++;
    end
    step(1'b1, 1'b0, 16'd272);
    n_checks++;
    if (bus.fifo_count !== 5'd16 || bus.fifo_full !== 1'b1)
      $display("FAIL fill_overflow_drop: got count=%0d full=%b want count=16 full=1",
               bus.fifo_count, bus.fifo_full);
    else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
    n_checks++;
    if (bus.overflow !== 1'b1) $display("FAIL overflow_flag: got %b want 1", bus.overflow);
    else n_pass++;
`endif
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (bus.output_data !== 16'(256 + i) || bus.output_data !== m_out)
        $display("FAIL drain_data %0d: got %h want %h", i, bus.output_data, 16'(256 + i));
      else n_pass++;
      n_checks++;
      if (bus.fifo_count !== 5'(15 - i) || bus.fifo_empty !== (i == 15) || bus.fifo_full !== 1'b0)
        $display("FAIL drain_flags %0d: got count=%0d empty=%b full=%b want count=%0d empty=%b",
                 i, bus.fifo_count, bus.fifo_empty, bus.fifo_full, 15 - i, (i == 15));
      else n_pass++;
    end
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (bus.output_data !== 16'd271 || bus.fifo_empty !== 1'b1)
      $display("FAIL drain_underflow_hold: got data=%h empty=%b want data=010f empty=1",
               bus.output_data, bus.fifo_empty);
    else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
    n_checks++;
    if (bus.underflow !== 1'b1) $display("FAIL underflow_flag: got %b want 1", bus.underflow);
    else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (bus.output_data !== m_out)
        $display("FAIL wrap_pre_data %0d: got %h want %h", i, bus.output_data, m_out);
      else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 16'h0A00 + 16'(i));
      n_checks++;
      if (bus.fifo_full !== (i == 15) || bus.fifo_count !== 5'(i + 1))
        $display("FAIL wrap_fill %0d: got full=%b count=%0d want full=%b count=%0d",
                 i, bus.fifo_full, bus.fifo_count, (i == 15), i + 1);
      else n_pass++;
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (bus.output_data !== 16'h0A00 + 16'(i) || bus.fifo_empty !== (i == 15))
        $display("FAIL wrap_drain %0d: got data=%h empty=%b want data=%h empty=%b",
                 i, bus.output_data, bus.fifo_empty, 16'h0A00 + 16'(i), (i == 15));
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] held;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 16'($urandom));
      n_checks++;
      if (bus.fifo_count !== 5'd5 || bus.output_data !== m_out)
        $display("FAIL simul_mid %0d: got count=%0d data=%h want count=5 data=%h",
                 i, bus.fifo_count, bus.output_data, m_out);
      else n_pass++;
    end
    while (mq.size() > 0) step(1'b0, 1'b1, '0);
    held = m_out;
    step(1'b1, 1'b1, 16'hBEEF);
    n_checks++;
    if (bus.fifo_count !== 5'd1 || bus.output_data !== held || bus.fifo_empty !== 1'b0)
      $display("FAIL simul_empty: got count=%0d data=%h empty=%b want count=1 data=%h empty=0",
               bus.fifo_count, bus.output_data, bus.fifo_empty, held);
    else n_pass++;
    while (mq.size() < DEPTH) step(1'b1, 1'b0, 16'($urandom));
    step(1'b1, 1'b1, 16'hDEAD);
    n_checks++;
    if (bus.fifo_count !== 5'd15 || bus.fifo_full !== 1'b0 || bus.output_data !== 16'hBEEF)
      $display("FAIL simul_full: got count=%0d full=%b data=%h want count=15 full=0 data=beef",
               bus.fifo_count, bus.fifo_full, bus.output_data);
    else n_pass++;
  endtask

  task automatic test_random();
    int pw;
    for (int i = 0; i < 600; i++) begin
      // Bias phases push occupancy toward full, then toward empty.
      pw = ((i / 75) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 50, 16'($urandom));
      n_checks++;
      if (bus.fifo_count !== 5'(mq.size()) || bus.fifo_full !== (mq.size() == DEPTH) ||
          bus.fifo_empty !== (mq.size() == 0) || bus.output_data !== m_out)
        $display("FAIL random %0d: got count=%0d full=%b empty=%b data=%h want count=%0d data=%h",
                 i, bus.fifo_count, bus.fifo_full, bus.fifo_empty, bus.output_data,
                 mq.size(), m_out);
      else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
      n_checks++;
      if (bus.overflow !== m_ovf || bus.underflow !== m_unf)
        $display("FAIL random_errflags %0d: got %b%b want %b%b",
                 i, bus.overflow, bus.underflow, m_ovf, m_unf);
      else n_pass++;
`endif
    end
  endtask

  task automatic test_mid_reset();
    while (mq.size() > 0) step(1'b0, 1'b1, '0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 16'($urandom));
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.fifo_empty !== 1'b1 || bus.fifo_full !== 1'b0 || bus.fifo_count !== '0 ||
        bus.output_data !== '0)
      $display("FAIL mid_reset: got empty=%b full=%b count=%0d data=%h want 1 0 0 0000",
               bus.fifo_empty, bus.fifo_full, bus.fifo_count, bus.output_data);
    else n_pass++;
`ifdef FIFO_ERR_FLAGS_EN
    n_checks++;
    if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0)
      $display("FAIL mid_reset_errflags: got %b%b want 00", bus.overflow, bus.underflow);
    else n_pass++;
`endif
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 16'h1234);
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (bus.output_data !== 16'h1234 || bus.fifo_empty !== 1'b1)
      $display("FAIL mid_reset_after: got data=%h empty=%b want data=1234 empty=1",
               bus.output_data, bus.fifo_empty);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
